// File: rtl/uart_axil_pkg.sv
// rtl/uart_axil_pkg.sv - shared constants, FSM state type and status helper for the UART to AXI-Lite bridge
// Contents: command bytes, response status codes, AXI resp codes, bridge_state_t, resp_status()
package uart_axil_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;

  localparam logic [7:0] ST_OKAY     = 8'h00;
  localparam logic [7:0] ST_BADCMD   = 8'hEE;
  localparam logic [7:0] ST_ERR_BASE = 8'h80;

  localparam logic [1:0] OKAY        = 2'b00;
  localparam logic [1:0] SLVERR      = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_ADDR = 3'd1,
    S_RX_DATA = 3'd2,
    S_AXI_W   = 3'd3,
    S_AXI_B   = 3'd4,
    S_AXI_AR  = 3'd5,
    S_AXI_R   = 3'd6,
    S_TX_RESP = 3'd7
  } bridge_state_t;

  // Status byte reported to the host for an AXI response code.
  function automatic logic [7:0] resp_status(input logic [1:0] resp);
    return (resp == OKAY) ? ST_OKAY : (ST_ERR_BASE | {6'd0, resp});
  endfunction

endpackage

// File: rtl/uart_axil_bridge_resp_serializer.sv
// rtl/uart_axil_bridge_resp_serializer.sv - sends a 1- or 5-byte response, MSB byte first
// Ports: clk, resetn; start/payload[39:0]/len[2:0] load a response;
//        tx_data/tx_valid/tx_ready byte stream out; done pulses on the last byte handshake
module resp_serializer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [39:0] payload,
  input  logic [2:0]  len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [39:0] sr_q;
  logic [2:0]  left_q;
  logic        valid_q;
  logic        fire;

  assign fire     = valid_q & tx_ready;
  assign done     = fire && (left_q == 3'd0);
  // The byte on the wire is always the top of the shift register, so it
  // cannot change while the transmitter stalls.
  assign tx_data  = sr_q[39:32];
  assign tx_valid = valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q    <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (start) begin
      sr_q    <= payload;
      left_q  <= len - 3'd1;
      valid_q <= 1'b1;
    end else if (fire) begin
      if (left_q == 3'd0) begin
        valid_q <= 1'b0;
      end else begin
        sr_q   <= {sr_q[31:0], 8'h00};
        left_q <= left_q - 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_axil_bridge.sv
// rtl/uart_axil_bridge.sv - parses UART command frames into single AXI-Lite transactions and returns status/data
// Ports: clk, resetn; rx_data/rx_valid/rx_ready from the UART receiver;
//        tx_data/tx_valid/tx_ready to the UART transmitter; m_axi_* AXI-Lite master; busy
module uart_axil_bridge
  import uart_axil_pkg::*;
#(
  parameter int RX_TIMEOUT = 100000,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy
);

  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  bridge_state_t     state_q, state_d;
  logic              is_write_q;
  logic [1:0]        byte_cnt_q;
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              awvalid_q, wvalid_q, arvalid_q;
  logic              rx_ready_q, bready_q, rready_q;
  logic              rx_fire, in_rx, timeout, last_byte;
  logic              ser_start, ser_done;
  logic [39:0]       ser_payload;
  logic [2:0]        ser_len;

  assign rx_fire   = rx_valid & rx_ready_q;
  assign in_rx     = (state_q == S_RX_ADDR) || (state_q == S_RX_DATA);
  assign timeout   = in_rx && (timer_q == TW'(RX_TIMEOUT - 1));
  assign last_byte = rx_fire && (byte_cnt_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    ser_payload = '0;
    ser_len     = 3'd1;
    case (state_q)
      S_IDLE:
        if (rx_fire) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            state_d = S_RX_ADDR;
          end else begin
            state_d     = S_TX_RESP;
            ser_payload = {ST_BADCMD, 32'h0};
          end
        end
      // Timeout wins over a byte landing in the same cycle: the frame is dropped.
      S_RX_ADDR:
        if (timeout)        state_d = S_IDLE;
        else if (last_byte) state_d = is_write_q ? S_RX_DATA : S_AXI_AR;
      S_RX_DATA:
        if (timeout)        state_d = S_IDLE;
        else if (last_byte) state_d = S_AXI_W;
      // A valid already dropped means its handshake is done.
      S_AXI_W:
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_d = S_AXI_B;
      S_AXI_B:
        if (m_axi_bvalid && bready_q) begin
          state_d     = S_TX_RESP;
          ser_payload = {resp_status(m_axi_bresp), 32'h0};
        end
      S_AXI_AR:
        if (arvalid_q && m_axi_arready) state_d = S_AXI_R;
      S_AXI_R:
        if (m_axi_rvalid && rready_q) begin
          state_d     = S_TX_RESP;
          ser_payload = {resp_status(m_axi_rresp), m_axi_rdata};
          ser_len     = 3'd5;
        end
      S_TX_RESP:
        if (ser_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ser_start = (state_d == S_TX_RESP) && (state_q != S_TX_RESP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Handshake outputs are registered from the next state so they are
      // glitch-free and all read 0 while in reset.
      rx_ready_q <= (state_d == S_IDLE) || (state_d == S_RX_ADDR) || (state_d == S_RX_DATA);
      bready_q   <= (state_d == S_AXI_B);
      rready_q   <= (state_d == S_AXI_R);

      if (state_q == S_IDLE && rx_fire) is_write_q <= (rx_data == CMD_WRITE);

      if (state_d != state_q) byte_cnt_q <= '0;
      else if (rx_fire)       byte_cnt_q <= byte_cnt_q + 2'd1;

      if (!in_rx || rx_fire || state_d != state_q) timer_q <= '0;
      else                                         timer_q <= timer_q + TW'(1);

      if (rx_fire && !timeout) begin
        if (state_q == S_RX_ADDR) addr_q  <= {addr_q[ADDR_W-9:0], rx_data};
        if (state_q == S_RX_DATA) wdata_q <= {wdata_q[23:0], rx_data};
      end

      // Valids rise together with the state change, giving 1-cycle latency
      // from the last rx byte.
      if (state_d == S_AXI_W && state_q != S_AXI_W) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end else begin
        if (m_axi_awready) awvalid_q <= 1'b0;
        if (m_axi_wready)  wvalid_q  <= 1'b0;
      end

      if (state_d == S_AXI_AR && state_q != S_AXI_AR) arvalid_q <= 1'b1;
      else if (m_axi_arready)                         arvalid_q <= 1'b0;
    end
  end

  resp_serializer u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .start    (ser_start),
    .payload  (ser_payload),
    .len      (ser_len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (ser_done)
  );

  assign rx_ready      = rx_ready_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_axil_bridge.sv
// tb/tb_uart_axil_bridge.sv - scoreboard bench for uart_axil_bridge with a reactive AXI-Lite slave
module tb_uart_axil_bridge;
  import uart_axil_pkg::*;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, busy;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  uart_axil_bridge #(.RX_TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] data; } aw_t;
  logic [7:0]  exp_tx[$];
  aw_t         exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [31:0] mem [logic [31:0]];

  bit          w_hold = 0;
  bit          force_rd = 0;
  logic [31:0] force_rdata = '0;
  logic [1:0]  bresp_k = OKAY, rresp_k = OKAY;
  int          tx_mode = 0;

  // AXI-Lite slave, decides at negedge; a handshake raised here completes at the next posedge.
  initial begin
    bit got_aw, got_w, got_ar, b_fire, r_fire;
    logic [31:0] cap_aw, cap_w, cap_ar;
    logic [3:0]  cap_strb;
    aw_t e;
    got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
    cap_aw = '0; cap_w = '0; cap_ar = '0; cap_strb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = OKAY;
    arready = 0; rvalid = 0; rdata = '0; rresp = OKAY;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
        continue;
      end
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      if (awready) begin awready = 0; got_aw = 1; end
      if (wready)  begin wready = 0;  got_w = 1;  end
      if (arready) begin arready = 0; got_ar = 1; end
      if (awvalid && !got_aw) begin awready = 1; cap_aw = awaddr; end
      if (wvalid && !got_w && !w_hold) begin wready = 1; cap_w = wdata; cap_strb = wstrb; end
      if (arvalid && !got_ar) begin arready = 1; cap_ar = araddr; end
      if (got_aw && got_w && !bvalid) begin
        got_aw = 0; got_w = 0;
        chk("aw_expected", 64'(exp_aw.size() > 0), 64'd1);
        if (exp_aw.size() > 0) begin
          e = exp_aw.pop_front();
          chk("awaddr", cap_aw, e.addr);
          chk("wdata", cap_w, e.data);
          chk("wstrb", cap_strb, 4'hF);
        end
        mem[cap_aw] = cap_w;
        bresp = bresp_k;
        bvalid = 1;
      end
      if (got_ar && !rvalid) begin
        got_ar = 0;
        chk("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
        if (exp_ar.size() > 0) chk("araddr", cap_ar, exp_ar.pop_front());
        rdata = force_rd ? force_rdata : (mem.exists(cap_ar) ? mem[cap_ar] : 32'h0);
        rresp = rresp_k;
        rvalid = 1;
      end
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
    end
  end

  // tx_ready: always high, or high one cycle in three; changed just after posedge.
  initial begin
    int tcnt;
    tcnt = 0;
    tx_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tx_ready = (tx_mode == 0) ? 1'b1 : (tcnt % 3 == 0);
    end
  end

  // TX monitor: pops the scoreboard on every byte handshake, checks stall stability.
  initial begin
    bit stalled;
    logic [7:0] prev;
    stalled = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin stalled = 0; continue; end
      if (tx_valid && stalled) chk("tx_stable", tx_data, prev);
      if (tx_valid && tx_ready) begin
        chk("tx_expected", 64'(exp_tx.size() > 0), 64'd1);
        if (exp_tx.size() > 0) chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      stalled = tx_valid && !tx_ready;
      prev = tx_data;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // All stimulus tasks start and end at a negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(CMD_WRITE);
    send_word(a);
    send_word(d);
    chk("aw_w_latency", {62'd0, awvalid, wvalid}, 64'd3);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(CMD_READ);
    send_word(a);
    chk("ar_latency", 64'(arvalid), 64'd1);
  endtask

  task automatic push_rd(input logic [7:0] st, input logic [31:0] d);
    exp_tx.push_back(st);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 2000) begin @(negedge clk); n++; end
    chk(name, 64'(n < 2000), 64'd1);
  endtask

  initial begin
    rx_valid = 0;
    rx_data = '0;
    #2 resetn = 0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 0);
    chk("rst_tx_valid", 64'(tx_valid), 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_wstrb", wstrb, 4'hF);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", 64'(busy), 0);
    resetn = 1;
    @(negedge clk);
    chk("idle_rx_ready", 64'(rx_ready), 1);

    // Write then read back
    exp_aw.push_back('{32'h8, 32'hDEADBEEF});
    exp_tx.push_back(8'h00);
    send_write(32'h8, 32'hDEADBEEF);
    wait_idle("write1_done");
    exp_ar.push_back(32'h8);
    push_rd(8'h00, 32'hDEADBEEF);
    send_read(32'h8);
    wait_idle("read1_done");

    // Unknown command, then a good read
    exp_tx.push_back(ST_BADCMD);
    send_byte(8'h41);
    chk("badcmd_no_axi", {62'd0, awvalid, arvalid}, 0);
    wait_idle("badcmd_done");
    exp_ar.push_back(32'h8);
    push_rd(8'h00, 32'hDEADBEEF);
    send_read(32'h8);
    wait_idle("read2_done");

    // Partial frame times out silently
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TO + 5) @(negedge clk);
    chk("timeout_busy", 64'(busy), 0);
    chk("timeout_rx_ready", 64'(rx_ready), 1);
    exp_ar.push_back(32'h0);
    push_rd(8'h00, 32'h0);
    send_read(32'h0);
    wait_idle("read0_done");

    // Read error with transmitter stalls
    force_rd = 1;
    force_rdata = 32'hDEADBEEF;
    rresp_k = SLVERR;
    tx_mode = 1;
    exp_ar.push_back(32'h10);
    push_rd(8'h82, 32'hDEADBEEF);
    send_read(32'h10);
    wait_idle("read_err_done");
    force_rd = 0;
    rresp_k = OKAY;
    tx_mode = 0;

    // Write error response
    bresp_k = SLVERR;
    exp_aw.push_back('{32'h20, 32'h12345678});
    exp_tx.push_back(8'h82);
    send_write(32'h20, 32'h12345678);
    wait_idle("write_err_done");
    bresp_k = OKAY;

    // Reset while waiting for wready
    w_hold = 1;
    send_write(32'h4, 32'h11223344);
    repeat (5) @(negedge clk);
    chk("hold_wvalid", 64'(wvalid), 1);
    chk("hold_awvalid", 64'(awvalid), 0);
    chk("hold_wdata", wdata, 32'h11223344);
    chk("hold_awaddr", awaddr, 32'h4);
    #2 resetn = 0;
    #1;
    chk("abort_valids", {62'd0, awvalid, wvalid}, 0);
    chk("abort_busy", 64'(busy), 0);
    @(negedge clk);
    w_hold = 0;
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    exp_aw.push_back('{32'h4, 32'h11223344});
    exp_tx.push_back(8'h00);
    send_write(32'h4, 32'h11223344);
    wait_idle("write_after_rst_done");
    exp_ar.push_back(32'h4);
    push_rd(8'h00, 32'h11223344);
    send_read(32'h4);
    wait_idle("read_after_rst_done");

    repeat (5) @(negedge clk);
    chk("tx_queue_empty", 64'(exp_tx.size()), 0);
    chk("aw_queue_empty", 64'(exp_aw.size()), 0);
    chk("ar_queue_empty", 64'(exp_ar.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
